trig_gen: RTL and testbench
===========================

# trig_gen

Programmable trigger-pulse generator in the 460 MHz counting clock domain. On a start request it waits a configurable delay, then emits a train of high pulses of configurable width and period, either for a fixed count or continuously until aborted. It is the source side of the trigger path: its output feeds the design's 2-FF edge detectors and counting logic. The generator guarantees that every pulse has at least one high and one low cycle so each edge is detectable downstream.

## Interface
- CNT_W, 32: width of all configuration values and counters.
- clk  in  1  counting clock, 460 MHz; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  synchronous stop; effective in any state.
- cfg_delay  in  CNT_W  cycles from acceptance to first rise (D).
- cfg_width  in  CNT_W  high cycles per pulse (W).
- cfg_period  in  CNT_W  rise-to-rise cycles (P).
- cfg_count  in  CNT_W  number of pulses (N); 0 means continuous.
- trig  out  1  registered trigger output.
- busy  out  1  high from acceptance until train completes or aborts.
- done  out  1  one-cycle pulse at normal completion.
- pulse_cnt  out  CNT_W  pulses issued since last acceptance.

## Operation
- States: IDLE, DELAY, HIGH, LOW.
- IDLE: trig=0, busy=0. When start=1 and abort=0, latch D, W', P', N into shadow registers, clear pulse_cnt, set busy, and go to DELAY. Config inputs are ignored after acceptance.
- Width/period sanitising on latch:
  - W' = max(W, 1).
  - P' = max(P, W'+1). This guarantees at least 1 low cycle.
- DELAY: count D cycles, then HIGH. When D=0, DELAY lasts zero extra cycles.
- HIGH: trig=1 for W' cycles. pulse_cnt increments by 1 on the cycle trig rises.
- LOW: trig=0 for P'-W' cycles. After that:
  - if N≠0 and pulse_cnt==N, go to IDLE;
  - otherwise go to HIGH.
- Completion is evaluated at the falling edge of the last pulse. In the same cycle: trig=0, busy=0, done=1 for one cycle, and the state returns to IDLE. The trailing LOW of the last pulse is not waited out.
- Continuous mode (N=0): pulse_cnt wraps 2^CNT_W-1 → 0, and the train continues.
- start while busy: ignored, with no effect on the running train.
- abort: on the next edge trig=0, busy=0, done stays 0, and the state goes to IDLE. pulse_cnt holds its value. abort and start in the same IDLE cycle: abort wins and nothing is accepted.
- Async reset: state=IDLE, trig=0, busy=0, done=0, pulse_cnt=0, shadow registers=0. This applies immediately, including mid-pulse.
- Arithmetic: all counters are unsigned CNT_W bits. Computing W'+1 must not overflow: if W'=2^CNT_W-1, then P' saturates at 2^CNT_W-1, W' is reduced to P'-1, and the low time is 1 cycle.

## Timing
- Edge 0 is the clk edge that samples start=1 in IDLE.
- busy=1 after edge 0.
- Pulse k (k=0,1,…) rises after edge D+1+k·P' and falls after edge D+1+k·P'+W'.
- pulse_cnt shows k+1 after the rise edge of pulse k.
- Last pulse (k=N-1) falls after edge E=D+1+(N-1)·P'+W'. After edge E: busy=0 and done=1. After edge E+1: done=0.
- Earliest re-accept: start sampled at edge E+1.
- abort sampled at edge A: trig=0 and busy=0 after edge A.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 with toggling inputs → trig=0, busy=0, done=0, pulse_cnt=0. Release → stays IDLE.
- Basic train: D=3, W=2, P=5, N=3, start at edge 0 → rises after edges 4, 9, 14; falls after 6, 11, 16; done=1 only after edge 16; busy=0 after 16; pulse_cnt=3.
- Sanitising: D=0, W=0, P=0, N=2 → W'=1, P'=2; rises after edges 1 and 3; done after edge 4. A downstream edge_detect shows 2 pos and 2 neg edges.
- Continuous + abort: N=0, W=1, P=3, D=0; assert abort with start re-pulsed mid-train → start ignored; trig=0, busy=0 next edge; done never asserted; pulse_cnt holds.
- Collisions: start and abort in the same IDLE cycle → busy stays 0. start during busy → timing identical to the uninterrupted run.
- Async reset mid-HIGH of pulse 2 of 4 → trig drops without a clock edge; the next start runs a fresh train with pulse_cnt from 0.

Source files
------------

// File: rtl/trig_gen.sv
// Programmable trigger-pulse generator: start -> delay -> train of W-high / P-period pulses,
// either N pulses or continuous until abort. All outputs are registered.
module trig_gen #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             trig,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   typedef enum logic [1:0] {StIdle, StDelay, StHigh, StLow} state_e;

   localparam logic [CNT_W-1:0] One    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] MaxVal = '1;

   state_e           state;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] high_m1;
   logic [CNT_W-1:0] low_m1;
   logic [CNT_W-1:0] count_s;

   logic [CNT_W-1:0] w_san;
   logic [CNT_W-1:0] p_san;
   logic             last_pulse;

   // Width >= 1 and period >= width + 1, so every pulse has a high and a low cycle.
   // A maximal width cannot take +1, so the period saturates and the width gives way.
   always_comb begin
      w_san = (cfg_width == '0) ? One : cfg_width;
      p_san = cfg_period;
      if (w_san == MaxVal) begin
         p_san = MaxVal;
         w_san = MaxVal - One;
      end else if (cfg_period <= w_san) begin
         p_san = w_san + One;
      end
   end

   assign last_pulse = (count_s != '0) && (pulse_cnt == count_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         timer     <= '0;
         high_m1   <= '0;
         low_m1    <= '0;
         count_s   <= '0;
         trig      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= StIdle;
            trig  <= 1'b0;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (start) begin
                     high_m1   <= w_san - One;
                     low_m1    <= p_san - w_san - One;
                     count_s   <= cfg_count;
                     timer     <= cfg_delay;
                     pulse_cnt <= '0;
                     busy      <= 1'b1;
                     state     <= StDelay;
                  end
               end
               StDelay, StLow: begin
                  if (timer == '0) begin
                     trig      <= 1'b1;
                     pulse_cnt <= pulse_cnt + One;
                     timer     <= high_m1;
                     state     <= StHigh;
                  end else begin
                     timer <= timer - One;
                  end
               end
               StHigh: begin
                  if (timer == '0) begin
                     trig <= 1'b0;
                     // Completion is taken at the fall of the last pulse; its low time is skipped.
                     if (last_pulse) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StIdle;
                     end else begin
                        timer <= low_m1;
                        state <= StLow;
                     end
                  end else begin
                     timer <= timer - One;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trig_gen.sv
// Self-checking bench for trig_gen: timing-formula model compared every cycle, plus
// directed scenarios with hand-computed literal waveforms.
module tb_trig_gen;

   localparam longint unsigned MaxV = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] cfg_delay = '0;
   logic [31:0] cfg_width = '0;
   logic [31:0] cfg_period = '0;
   logic [31:0] cfg_count = '0;
   logic        trig;
   logic        busy;
   logic        done;
   logic [31:0] pulse_cnt;

   int n_chk = 0;
   int n_err = 0;

   trig_gen #(.CNT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_delay (cfg_delay),
      .cfg_width (cfg_width),
      .cfg_period(cfg_period),
      .cfg_count (cfg_count),
      .trig      (trig),
      .busy      (busy),
      .done      (done),
      .pulse_cnt (pulse_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outputs follow directly from the edge count since acceptance.
   logic            m_trig = 1'b0;
   logic            m_busy = 1'b0;
   logic            m_done = 1'b0;
   logic [31:0]     m_cnt = '0;
   longint unsigned md, mw, mp, mn, rel, mm, mk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_trig = 1'b0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_cnt  = '0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            if (abort) begin
               m_busy = 1'b0;
               m_trig = 1'b0;
            end else begin
               rel++;
               if (rel <= md) begin
                  m_trig = 1'b0;
               end else begin
                  mm     = rel - md - 1;
                  mk     = mm / mp;
                  m_trig = (mm % mp) < mw;
                  m_cnt  = 32'(mk + 1);
                  if (mn != 0 && rel == md + 1 + (mn - 1) * mp + mw) begin
                     m_busy = 1'b0;
                     m_done = 1'b1;
                     m_trig = 1'b0;
                  end
               end
            end
         end else if (start && !abort) begin
            mw = (cfg_width == 0) ? 1 : longint'(cfg_width);
            if (mw == MaxV) begin
               mp = MaxV;
               mw = MaxV - 1;
            end else begin
               mp = (longint'(cfg_period) > mw) ? longint'(cfg_period) : mw + 1;
            end
            md     = cfg_delay;
            mn     = cfg_count;
            rel    = 0;
            m_busy = 1'b1;
            m_cnt  = '0;
            m_trig = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("trig", {63'd0, trig}, {63'd0, m_trig});
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("pulse_cnt", {32'd0, pulse_cnt}, {32'd0, m_cnt});
   end

   logic [63:0] cap_trig, cap_busy, cap_done;
   logic [31:0] cap_cnt [64];

   // Called just after a negedge; mask bit e drives the input sampled at edge e.
   task automatic run(input int n, input logic [63:0] smask, input logic [63:0] amask);
      cap_trig = '0;
      cap_busy = '0;
      cap_done = '0;
      start = smask[0];
      abort = amask[0];
      for (int e = 0; e < n; e++) begin
         @(negedge clk);
         cap_trig[e] = trig;
         cap_busy[e] = busy;
         cap_done[e] = done;
         cap_cnt[e]  = pulse_cnt;
         start = smask[e+1];
         abort = amask[e+1];
      end
   endtask

   task automatic set_cfg(input int d, input int w, input int p, input int n);
      cfg_delay  = d;
      cfg_width  = w;
      cfg_period = p;
      cfg_count  = n;
   endtask

   initial begin
      int pos, neg;
      logic prev;

      // Reset held with toggling inputs.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start     = 1'($urandom);
         abort     = 1'($urandom);
         cfg_delay = $urandom_range(0, 3);
         cfg_count = $urandom_range(0, 3);
      end
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_cnt", {32'd0, pulse_cnt}, 64'd0);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      run(3, 64'd0, 64'd0);
      chk("idle_after_reset", cap_busy[2:0], 64'd0);

      // Basic train D=3 W=2 P=5 N=3.
      set_cfg(3, 2, 5, 3);
      run(17, 64'd1, 64'd0);
      chk("basic_trig", {47'd0, cap_trig[16:0]}, {47'd0, 17'b01100011000110000});
      chk("basic_done", {47'd0, cap_done[16:0]}, 64'h10000);
      chk("basic_busy", {47'd0, cap_busy[16:0]}, 64'h0FFFF);
      chk("basic_cnt", {32'd0, cap_cnt[16]}, 64'd3);
      run(3, 64'd0, 64'd0);

      // Sanitising D=0 W=0 P=0 N=2 -> W'=1 P'=2.
      set_cfg(0, 0, 0, 2);
      run(6, 64'd1, 64'd0);
      chk("san_trig", {58'd0, cap_trig[5:0]}, {58'd0, 6'b001010});
      chk("san_done", {58'd0, cap_done[5:0]}, {58'd0, 6'b010000});
      chk("san_busy", {58'd0, cap_busy[5:0]}, {58'd0, 6'b001111});
      chk("san_cnt", {32'd0, cap_cnt[4]}, 64'd2);
      pos = 0;
      neg = 0;
      prev = 1'b0;
      for (int e = 0; e < 6; e++) begin
         if (cap_trig[e] && !prev) pos++;
         if (!cap_trig[e] && prev) neg++;
         prev = cap_trig[e];
      end
      chk("san_pos_edges", 64'(pos), 64'd2);
      chk("san_neg_edges", 64'(neg), 64'd2);

      // Continuous W=1 P=3 D=0, restart attempt mid-train, abort together with start.
      set_cfg(0, 1, 3, 0);
      run(14, 64'h221, 64'h200);
      chk("cont_trig", {50'd0, cap_trig[13:0]}, {50'd0, 14'b00000010010010});
      chk("cont_busy", {50'd0, cap_busy[13:0]}, 64'h01FF);
      chk("cont_done", {50'd0, cap_done[13:0]}, 64'd0);
      chk("cont_cnt_hold", {32'd0, cap_cnt[13]}, 64'd3);

      // start and abort in the same idle cycle.
      set_cfg(0, 1, 2, 1);
      run(4, 64'd1, 64'd1);
      chk("collide_busy", {60'd0, cap_busy[3:0]}, 64'd0);

      // start during busy (incl. the completion edge), then re-accept at E+1.
      set_cfg(3, 2, 5, 3);
      run(20, 64'h3_0021, 64'd0);
      chk("busy_start_trig", {47'd0, cap_trig[16:0]}, {47'd0, 17'b01100011000110000});
      chk("busy_start_done", {47'd0, cap_done[16:0]}, 64'h10000);
      chk("reaccept_busy", {63'd0, cap_busy[17]}, 64'd1);
      chk("reaccept_cnt", {32'd0, cap_cnt[17]}, 64'd0);
      run(3, 64'd0, 64'd1);

      // Async reset mid-HIGH of pulse 2 of 4 (D=1 W=3 P=6: rises after edges 2, 8).
      set_cfg(1, 3, 6, 4);
      run(10, 64'd1, 64'd0);
      chk("pre_rst_trig", {63'd0, cap_trig[9]}, 64'd1);
      chk("pre_rst_cnt", {32'd0, cap_cnt[9]}, 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_trig", {63'd0, trig}, 64'd0);
      chk("async_busy", {63'd0, busy}, 64'd0);
      chk("async_cnt", {32'd0, pulse_cnt}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_cfg(1, 3, 6, 2);
      run(12, 64'd1, 64'd0);
      chk("fresh_cnt0", {32'd0, cap_cnt[0]}, 64'd0);
      chk("fresh_cnt_first", {32'd0, cap_cnt[2]}, 64'd1);
      chk("fresh_done", {52'd0, cap_done[11:0]}, 64'h800);
      run(3, 64'd0, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
